// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding and
// legal pattern-length bounds.
package seq_det_pkg;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with loadable pattern and overlap control.
// Define SEQ_DET_COUNT_EN to add the saturating match_count output.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               data_in,
    input  logic               data_valid,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               pattern_load,
    input  logic               overlap_en,
`ifdef SEQ_DET_COUNT_EN
    output logic               found_flag,
    output logic [CNT_W-1:0]   match_count
`else
    output logic               found_flag
`endif
);

    localparam int unsigned          FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]    FILL_ARM = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN);

    if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX) || (CNT_W == 0)) begin : g_bad_param
        $error("seq_detector: PAT_LEN or CNT_W out of range");
    end

    state_t             state, state_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt, fill_inc;
    logic [PAT_LEN-1:0] window, window_nxt, shifted;
    logic [PAT_LEN-1:0] pat_reg, pat_nxt;
    logic               found_nxt;
    logic               match;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fill       <= '0;
            window     <= '0;
            pat_reg    <= '0;
            found_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill       <= fill_nxt;
            window     <= window_nxt;
            pat_reg    <= pat_nxt;
            found_flag <= found_nxt;
        end
    end

    // ARMED means a full window; one bit short also qualifies since this bit completes it
    always_comb begin
        state_nxt  = state;
        fill_nxt   = fill;
        window_nxt = window;
        pat_nxt    = pat_reg;
        found_nxt  = 1'b0;

        shifted  = {window[PAT_LEN-2:0], data_in};
        fill_inc = (state == ARMED) ? fill : fill + FILL_W'(1);
        match    = (shifted == pat_reg) && ((state == ARMED) || (fill == FILL_ARM));

        if (pattern_load) begin
            pat_nxt    = pattern;
            window_nxt = '0;
            fill_nxt   = '0;
        end else if (data_valid) begin
            window_nxt = shifted;
            found_nxt  = match;
            fill_nxt   = (match && !overlap_en) ? '0 : fill_inc;
        end

        if (fill_nxt == '0) begin
            state_nxt = IDLE;
        end else if (fill_nxt == FILL_MAX) begin
            state_nxt = ARMED;
        end else begin
            state_nxt = FILLING;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    // Counts at the same edge that raises found_flag
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (found_nxt),
        .clr     (pattern_load),
        .count   (match_count)
    );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector (PAT_LEN=5); a second CNT_W=2 instance
// shares the stimulus to exercise counter saturation.
module tb_seq_detector;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       data_in;
    logic       data_valid;
    logic [4:0] pattern;
    logic       pattern_load;
    logic       overlap_en;
    logic       found_flag;
    logic       sat_found;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] match_count;
    logic [1:0] sat_count;
`endif

    int checks    = 0;
    int failures  = 0;
    int exp_cnt8  = 0;
    int exp_cnt2  = 0;

    always #5 clock = ~clock;

    seq_detector #(.PAT_LEN(5), .CNT_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .pattern      (pattern),
        .pattern_load (pattern_load),
        .overlap_en   (overlap_en),
`ifdef SEQ_DET_COUNT_EN
        .found_flag   (found_flag),
        .match_count  (match_count)
`else
        .found_flag   (found_flag)
`endif
    );

    seq_detector #(.PAT_LEN(5), .CNT_W(2)) dut_sat (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .pattern      (pattern),
        .pattern_load (pattern_load),
        .overlap_en   (overlap_en),
`ifdef SEQ_DET_COUNT_EN
        .found_flag   (sat_found),
        .match_count  (sat_count)
`else
        .found_flag   (sat_found)
`endif
    );

    typedef struct {
        logic       ld;
        logic [4:0] pat;
        logic       v;
        logic       d;
        logic       ovl;
        logic       exp_f;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic ld, logic [4:0] pat, logic v, logic d, logic ovl, logic exp_f);
        vec_t e;
        e.ld = ld; e.pat = pat; e.v = v; e.d = d; e.ovl = ovl; e.exp_f = exp_f;
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus, then compare against the count model
    task automatic step(input logic ld, input logic [4:0] pat, input logic v, input logic d,
                        input logic ovl, input logic exp_f, input string name);
        pattern_load = ld;
        pattern      = pat;
        data_valid   = v;
        data_in      = d;
        overlap_en   = ovl;
        @(posedge clock);
        #1;
        if (ld) begin
            exp_cnt8 = 0;
            exp_cnt2 = 0;
        end else if (exp_f) begin
            if (exp_cnt8 != 255) exp_cnt8++;
            if (exp_cnt2 != 3) exp_cnt2++;
        end
        check({name, "_found"}, 32'(found_flag), 32'(exp_f));
        check({name, "_sat_found"}, 32'(sat_found), 32'(exp_f));
`ifdef SEQ_DET_COUNT_EN
        check({name, "_count"}, 32'(match_count), 32'(exp_cnt8));
        check({name, "_sat_count"}, 32'(sat_count), 32'(exp_cnt2));
`endif
    endtask

    task automatic send_bits(input logic [4:0] bits, input logic ovl, input logic last_hit, input string name);
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, 5'b0, 1'b1, bits[i], ovl, (i == 0) ? last_hit : 1'b0, name);
        end
    endtask

    initial begin
        logic [4:0] zeros_one;
        zeros_one    = 5'b00001;
        reset_n      = 1'b0;
        data_in      = 1'b0;
        data_valid   = 1'b0;
        pattern      = 5'b0;
        pattern_load = 1'b0;
        overlap_en   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_found", 32'(found_flag), 32'd0);
`ifdef SEQ_DET_COUNT_EN
        check("reset_count", 32'(match_count), 32'd0);
`endif
        reset_n = 1'b1;

        // basic 00001
        add(1, 5'b00001, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 1); add(0, 0, 0, 1, 1, 0);
        // overlapping 01010 on 01010101
        add(1, 5'b01010, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 1, 1, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 1); add(0, 0, 1, 1, 1, 0); add(0, 0, 1, 0, 1, 1); add(0, 0, 1, 1, 1, 0);
        // non-overlapping, same stream
        add(1, 5'b01010, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 1); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0);
        // data on the load cycle must not enter the window
        add(1, 5'b10000, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0);
        // overlap_en dropped mid-stream applies from the next valid bit
        add(1, 5'b01010, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 1, 1, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 1); add(0, 0, 1, 1, 1, 0); add(0, 0, 1, 0, 0, 1); add(0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ld, tbl[i].pat, tbl[i].v, tbl[i].d, tbl[i].ovl, tbl[i].exp_f,
                 $sformatf("vec%0d", i));
        end

        // gaps of three invalid cycles between bits
        step(1, 5'b00001, 0, 0, 1, 0, "gap_load");
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 1, zeros_one[i], 1, (i == 0), $sformatf("gap_bit%0d", 4 - i));
            for (int g = 0; g < 3; g++) begin
                step(0, 0, 0, 1, 1, 0, $sformatf("gap_idle%0d_%0d", 4 - i, g));
            end
        end

        // reload after four bits
        step(1, 5'b00001, 0, 0, 1, 0, "reload_a");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0, "reload_pre");
        step(1, 5'b11111, 1, 0, 1, 0, "reload_b");
        send_bits(5'b11111, 1'b1, 1'b1, "reload_ones");

        // reset mid-pattern
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0, "rst_pre");
        reset_n = 1'b0;
        #2;
        check("rst_async_found", 32'(found_flag), 32'd0);
`ifdef SEQ_DET_COUNT_EN
        check("rst_async_count", 32'(match_count), 32'd0);
`endif
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(0, 0, 1, 1, 1, 0, "rst_after_bit");
        step(1, 5'b00001, 0, 0, 1, 0, "rst_reload");
        send_bits(5'b00001, 1'b1, 1'b1, "rst_seq");

        // five non-overlapping matches saturate the 2-bit counter
        step(1, 5'b00001, 0, 0, 0, 0, "sat_load");
        for (int m = 0; m < 5; m++) send_bits(5'b00001, 1'b0, 1'b1, $sformatf("sat_m%0d", m));
`ifdef SEQ_DET_COUNT_EN
        check("sat_final_wide", 32'(match_count), 32'd5);
        check("sat_final_narrow", 32'(sat_count), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
